synchronous_fifo: RTL
=====================

# synchronous_fifo

Single-clock, parametrised FIFO for buffering data inside one clock domain, the same-domain successor to our dual-clock FIFO. Adds a fill count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable show-ahead (first-word-fall-through) read mode. Sits between a producer and a consumer sharing `fifo_clk`, using the same write/read-enable handshake as the dual-clock FIFO.

## Interface
- `address_bus_length`, 4: pointer width; depth D = 2**address_bus_length.
- `data_bus_length`, 8: data word width.
- `almost_full_level`, 12: `fifo_almost_full` asserts when count >= this value; legal range 1..D.
- `almost_empty_level`, 2: `fifo_almost_empty` asserts when count <= this value; legal range 0..D-1.
- `show_ahead`, 0: 0 = standard registered read; 1 = first-word-fall-through.

- `fifo_clk`  in  1  the only clock; all state changes on its rising edge.
- `fifo_rst`  in  1  synchronous, active-high reset.
- `write_enable`  in  1  write request.
- `trans_data`  in  data_bus_length  write data.
- `read_enable`  in  1  read request (in show-ahead mode, the head acknowledge).
- `recv_data`  out  data_bus_length  read data.
- `read_valid`  out  1  `recv_data` holds valid data (see Operation).
- `fifo_full`, `fifo_empty`  out  1  count == D, count == 0.
- `fifo_almost_full`, `fifo_almost_empty`  out  1  threshold flags.
- `fifo_count`  out  address_bus_length+1  current occupancy, 0..D.
- `overflow`, `underflow`  out  1  sticky error flags.

## Operation
- Storage: D x data_bus_length array, not reset. Write and read pointers are address_bus_length bits and wrap naturally from D-1 to 0. Occupancy is a separate (address_bus_length+1)-bit counter.
- Write accepted = `write_enable & !fifo_full`. An accepted write stores `trans_data` at the write pointer, then the pointer increments.
- Read accepted = `read_enable & !fifo_empty`. The read pointer increments on each accepted read.
- Flags use the registered state at the start of the cycle. When full, a write is rejected even if a read is accepted in the same cycle. When empty, a read is rejected even if a write is accepted in the same cycle.
- Count update: +1 for write only, -1 for read only, unchanged for both or neither.
- Rejected write (`write_enable & fifo_full`): sets `overflow`. Memory, pointer and count are unchanged.
- Rejected read (`read_enable & fifo_empty`): sets `underflow`. Pointer and count are unchanged. `recv_data` holds its value.
- `overflow` and `underflow` clear only on `fifo_rst`.
- show_ahead = 0: an accepted read registers the head entry into `recv_data`. `read_valid` pulses for exactly that following cycle. Otherwise `recv_data` holds its last value.
- show_ahead = 1: `recv_data` = memory[read pointer] combinationally, and `read_valid` = `!fifo_empty`. An accepted read advances to the next entry.

## Timing
- Values at reset (cycle after `fifo_rst` sampled high): pointers 0, `fifo_count` 0, `fifo_empty` 1, `fifo_full` 0, `fifo_almost_empty` 1, `fifo_almost_full` 0, `overflow` 0, `underflow` 0, `read_valid` 0, registered `recv_data` 0.
- All flags and the count are registered. They reflect an accepted operation on the edge following it.
- Write-to-read latency: data written at edge N is readable (`fifo_empty` = 0) from edge N+1.
  - show_ahead = 1: that data appears on `recv_data` after edge N+1.
  - show_ahead = 0: with `read_enable` high in cycle N+1, data appears after edge N+2.
- Reset mid-operation: contents are discarded and all state returns to reset values on the next edge. Write and read requests in the reset cycle are ignored.
- Full boundary: D accepted writes with no reads gives count = D, `fifo_full` = 1, and `fifo_almost_full` = 1.
- Empty boundary: the last read gives count = 0 and `fifo_empty` = 1 on the same edge.

## Test plan
- Reset: hold `fifo_rst` for 2 cycles with `write_enable` = `read_enable` = 1 -> every output at its reset value, `fifo_count` = 0, no error flags set.
- Fill and overflow (D = 16, show_ahead = 0): write 17..32 on consecutive cycles -> `fifo_count` = 16 and `fifo_full` = 1. Then:
  - `fifo_almost_full` rose when count reached 12.
  - A 17th write of 99 sets `overflow`, and count stays 16.
- Drain and underflow: read 16 times -> `recv_data` = 17..32 in order, each with a one-cycle `read_valid` pulse. `fifo_empty` = 1 after the 16th read. A 17th read sets `underflow` and `recv_data` stays 32.
- Wrap-around and simultaneous operations: preload 10 entries, then 40 cycles of simultaneous read+write with an incrementing pattern -> count stays 10, data order is preserved across pointer wrap, no error flags set.
- Show-ahead (show_ahead = 1): write 5 -> `recv_data` = 5 and `read_valid` = 1 one edge later with no read issued. Write 6, then one read -> `recv_data` = 6.
- Reset mid-operation: reset with count = 7 -> next cycle count = 0, `fifo_empty` = 1. A subsequent write of 42 then a read returns 42.

Source files
------------

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky error flags
// and a choice of registered or first-word-fall-through read data.
module synchronous_fifo #(
  parameter int address_bus_length = 4,
  parameter int data_bus_length    = 8,
  parameter int almost_full_level  = 12,
  parameter int almost_empty_level = 2,
  parameter bit show_ahead         = 1'b0
) (
  input  logic                          fifo_clk,
  input  logic                          fifo_rst,
  input  logic                          write_enable,
  input  logic [data_bus_length-1:0]    trans_data,
  input  logic                          read_enable,
  output logic [data_bus_length-1:0]    recv_data,
  output logic                          read_valid,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          fifo_almost_full,
  output logic                          fifo_almost_empty,
  output logic [address_bus_length:0]   fifo_count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int count_width = address_bus_length + 1;
  localparam int depth       = 2 ** address_bus_length;
  localparam logic [address_bus_length:0] depth_count = count_width'(depth);
  localparam logic [address_bus_length:0] af_level    = count_width'(almost_full_level);
  localparam logic [address_bus_length:0] ae_level    = count_width'(almost_empty_level);

  logic [data_bus_length-1:0]    mem [depth];
  logic [address_bus_length-1:0] wr_ptr;
  logic [address_bus_length-1:0] rd_ptr;
  logic [address_bus_length:0]   count;
  logic [address_bus_length:0]   count_next;
  logic                          wr_accept;
  logic                          rd_accept;

  // Acceptance looks only at the registered flags, so a full FIFO refuses a
  // write even when a read frees a slot on the same edge (and vice versa).
  always_comb begin
    wr_accept  = write_enable & ~fifo_full;
    rd_accept  = read_enable & ~fifo_empty;
    count_next = count;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge fifo_clk) begin
    if (fifo_rst) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      fifo_full         <= 1'b0;
      fifo_empty        <= 1'b1;
      fifo_almost_full  <= 1'b0;
      fifo_almost_empty <= 1'b1;
      overflow          <= 1'b0;
      underflow         <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
      count             <= count_next;
      fifo_full         <= (count_next == depth_count);
      fifo_empty        <= (count_next == '0);
      fifo_almost_full  <= (count_next >= af_level);
      fifo_almost_empty <= (count_next <= ae_level);
      if (write_enable & fifo_full) overflow  <= 1'b1;
      if (read_enable & fifo_empty) underflow <= 1'b1;
    end
  end

  // Storage is deliberately left unreset; only the pointers define contents.
  always_ff @(posedge fifo_clk) begin
    if (wr_accept && !fifo_rst) mem[wr_ptr] <= trans_data;
  end

  assign fifo_count = count;

  if (show_ahead) begin : g_show_ahead
    assign recv_data  = mem[rd_ptr];
    assign read_valid = ~fifo_empty;
  end else begin : g_registered
    logic [data_bus_length-1:0] read_data;
    logic                       read_pulse;

    always_ff @(posedge fifo_clk) begin
      if (fifo_rst) begin
        read_data  <= '0;
        read_pulse <= 1'b0;
      end else begin
        read_pulse <= rd_accept;
        if (rd_accept) read_data <= mem[rd_ptr];
      end
    end

    assign recv_data  = read_data;
    assign read_valid = read_pulse;
  end

endmodule
